stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Control and sequencing block for the DE10 mm:ss stopwatch. It debounces the two active-low push keys and runs a start/stop/lap/clear state machine. It generates the 1 Hz count enable from the board clock and owns the BCD minute/second counters. It outputs four BCD digits, live or lap-frozen, to the existing 7-segment decoders.

Parameters:
TICK_DIV, 50000000, clock cycles per counted second; prescaler terminal count is TICK_DIV-1.
DB_CYCLES, 1000000, consecutive stable synchronized cycles required before a key level is accepted (20 ms at 50 MHz).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
key  input  2  raw push keys, active-low; key[0] = lap/clear, key[1] = start/stop.
digit_mt  output  4  BCD minute tens, 0-5.
digit_mo  output  4  BCD minute ones, 0-9.
digit_st  output  4  BCD second tens, 0-5.
digit_so  output  4  BCD second ones, 0-9.
state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, LAP=3.
tick  output  1  one-cycle pulse on each counted second.
wrap  output  1  one-cycle pulse when the count rolls from 59:59 to 00:00.

Behaviour:
- Reset values:
  - All digits, tick, wrap and the prescaler are 0; state is IDLE.
  - Sync flops and debounced key levels are 1 (released); lap latch is 00:00.
- Key path, per key:
  - 2-FF synchronizer, then a debounce counter.
  - The counter clears whenever the synchronized level equals the debounced level. Otherwise it increments.
  - When the counter reaches DB_CYCLES-1, the debounced level takes the synchronized level and the counter clears.
  - A press pulse is one cycle, generated on the debounced 1->0 transition. Release generates nothing.
  - Pin-to-pulse latency is 2 + DB_CYCLES cycles. The state register updates on the clock edge ending the pulse cycle.
  - A bounce shorter than DB_CYCLES produces no pulse.
- FSM transitions, keyed on press pulses:
  - IDLE: key[1] -> RUN; key[0] ignored.
  - RUN: key[1] -> PAUSE; key[0] -> LAP, capturing the lap latch.
  - LAP: key[1] -> PAUSE, releasing the freeze; key[0] -> RUN, releasing the freeze.
  - PAUSE: key[1] -> RUN; key[0] -> IDLE, clearing counters, prescaler and lap latch to 0.
  - Both pulses in the same cycle: key[0] is acted on and key[1] is dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and LAP.
  - At terminal count it returns to 0 and tick pulses in the same cycle.
  - Holds its value in PAUSE, so a resume keeps the fractional second.
  - Clears only on reset or on PAUSE->IDLE.
- BCD counter, advanced on tick:
  - so 9->0 carries to st; st 5->0 carries to mo; mo 9->0 carries to mt; mt 5->0.
  - Exactly 59:59 + tick gives 00:00 with wrap high in that same cycle.
  - Keeps counting in LAP.
- Lap latch:
  - Loaded with the counter register value present in the cycle the key[0] pulse is seen in RUN. A tick in that same cycle is not included.
- Digit outputs:
  - Registered outputs.
  - Show the lap latch while state = LAP, otherwise the live counter.
  - Output lags the selected source by one cycle.
- Reset mid-operation: takes effect immediately regardless of state, including mid-debounce or mid-LAP. Digit outputs go to 0 asynchronously.
- Widths: no digit ever holds a value above its stated range. Illegal BCD is unreachable from reset.

Test Plan:
All scenarios use TICK_DIV=4 and DB_CYCLES=3.
1. Reset, then key[1] held low for 10 cycles -> state IDLE->RUN 6 cycles after the pin goes low. tick every 4 cycles; after 12 ticks, digits 00:12.
2. Key[1] low pulse of 2 cycles, then high (bounce) -> no press pulse and state unchanged. A held press afterwards gives exactly one transition; release gives none.
3. Preload by running to 59:58, then 2 more ticks -> 59:59 then 00:00. wrap high for exactly one cycle, coincident with the second tick.
4. In RUN at 00:05, press key[0] -> state LAP and outputs frozen at 00:05 while the internal count reaches 00:08. Press key[0] again -> state RUN and outputs show 00:08 one cycle later.
5. In RUN with the prescaler at 2, press key[1] -> PAUSE with digits and prescaler held. Resume with key[1] -> the next tick arrives 2 cycles after RUN re-entry. Pause again and press key[0] -> IDLE with 00:00.
6. Key[0] and key[1] press pulses in the same cycle while in RUN -> LAP, not PAUSE. Assert reset mid-LAP -> state IDLE and digits 00:00 immediately.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch key/display bundle.
// key: raw active-low keys; digit_*, state, tick, wrap: controller status.
interface stopwatch_ctrl_if;
  logic [1:0] key;
  logic [3:0] digit_mt;
  logic [3:0] digit_mo;
  logic [3:0] digit_st;
  logic [3:0] digit_so;
  logic [1:0] state;
  logic       tick;
  logic       wrap;

  modport master (
    output key,
    input  digit_mt, digit_mo,
    input  digit_st, digit_so,
    input  state, tick, wrap
  );

  modport slave (
    input  key,
    output digit_mt, digit_mo,
    output digit_st, digit_so,
    output state, tick, wrap
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// mm:ss stopwatch: key debounce, start/stop/lap/clear FSM, 1 Hz prescaler.
// Ports: clock, reset (async high), bus (slave): key in, digits/state/tick/wrap out.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int DB_CYCLES = 1000000
) (
  input logic             clock,
  input logic             reset,
  stopwatch_ctrl_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

  logic [1:0]    s1_q, s2_q;
  logic [1:0]    db_q, dbd_q;
  logic [DW-1:0] dbc_q [2];
  logic [1:0]    press;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q  <= 2'b11;
      s2_q  <= 2'b11;
      db_q  <= 2'b11;
      dbd_q <= 2'b11;
      for (int i = 0; i < 2; i++)
        dbc_q[i] <= '0;
    end else begin
      s1_q  <= bus.key;
      s2_q  <= s1_q;
      dbd_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == db_q[i]) begin
          dbc_q[i] <= '0;
        end else if (dbc_q[i] == DW'(DB_CYCLES - 1)) begin
          db_q[i]  <= s2_q[i];
          dbc_q[i] <= '0;
        end else begin
          dbc_q[i] <= dbc_q[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle pulse after the accepted level falls.
  assign press = dbd_q & ~db_q;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    mt_q, mo_q, st_q, so_q;
  logic [3:0]    mt_d, mo_d, st_d, so_d;
  logic [15:0]   lap_q;
  logic [15:0]   dig_q;
  logic          tick_q, wrap_q;
  logic          run, term, roll;
  logic [15:0]   cnt;

  assign run  = (state_q == RUN) || (state_q == LAP);
  assign term = run && (presc_q == PW'(TICK_DIV - 1));
  assign cnt  = {mt_q, mo_q, st_q, so_q};

  always_comb begin
    mt_d = mt_q;
    mo_d = mo_q;
    st_d = st_q;
    so_d = so_q;
    roll = 1'b0;
    if (term) begin
      if (so_q == 4'd9) begin
        so_d = 4'd0;
        if (st_q == 4'd5) begin
          st_d = 4'd0;
          if (mo_q == 4'd9) begin
            mo_d = 4'd0;
            if (mt_q == 4'd5) begin
              mt_d = 4'd0;
              roll = 1'b1;
            end else begin
              mt_d = mt_q + 4'd1;
            end
          end else begin
            mo_d = mo_q + 4'd1;
          end
        end else begin
          st_d = st_q + 4'd1;
        end
      end else begin
        so_d = so_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      mt_q    <= '0;
      mo_q    <= '0;
      st_q    <= '0;
      so_q    <= '0;
      lap_q   <= '0;
      dig_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      tick_q <= term;
      wrap_q <= roll;
      dig_q  <= (state_q == LAP) ? lap_q : cnt;
      if (run)
        presc_q <= term ? '0 : presc_q + 1'b1;
      mt_q <= mt_d;
      mo_q <= mo_d;
      st_q <= st_d;
      so_q <= so_d;
      // key[0] wins when both pulses coincide.
      unique case (state_q)
        IDLE: begin
          if (press[1] && !press[0])
            state_q <= RUN;
        end
        RUN: begin
          if (press[0]) begin
            state_q <= LAP;
            lap_q   <= cnt;
          end else if (press[1]) begin
            state_q <= PAUSE;
          end
        end
        LAP: begin
          if (press[0])
            state_q <= RUN;
          else if (press[1])
            state_q <= PAUSE;
        end
        PAUSE: begin
          if (press[0]) begin
            state_q <= IDLE;
            presc_q <= '0;
            mt_q    <= '0;
            mo_q    <= '0;
            st_q    <= '0;
            so_q    <= '0;
            lap_q   <= '0;
          end else if (press[1]) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.state    = state_q;
  assign bus.tick     = tick_q;
  assign bus.wrap     = wrap_q;
  assign bus.digit_mt = dig_q[15:12];
  assign bus.digit_mo = dig_q[11:8];
  assign bus.digit_st = dig_q[7:4];
  assign bus.digit_so = dig_q[3:0];

endmodule
